// File: rtl/ura_scoreboard.sv
// Unified-register-address scoreboard: tracks in-flight destinations and resolves stall/forward per source.
// Queries are combinational on registered slot state; busy_count is registered.
module ura_scoreboard #(
  parameter int URA_W  = 7,
  parameter int STAGES = 3,
  parameter int NDEST  = 3,
  parameter int NSRC   = 2,
  parameter int TW     = 2,
  localparam int SW    = (STAGES > 1) ? $clog2(STAGES) : 1,
  localparam int CW    = $clog2(STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  issue_valid,
  input  logic [NDEST*URA_W-1:0] issue_ura,
  input  logic [TW-1:0]         issue_tnew,
  input  logic                  advance,
  input  logic                  flush,
  input  logic [NSRC*URA_W-1:0] src_ura,
  input  logic [NSRC*TW-1:0]    src_tuse,
  output logic                  stall,
  output logic [NSRC-1:0]       fwd_hit,
  output logic [NSRC*SW-1:0]    fwd_stage,
  output logic [CW-1:0]         busy_count
);

  logic [STAGES-1:0]                  vld_q, vld_d;
  logic [STAGES-1:0][NDEST*URA_W-1:0] ura_q, ura_d;
  logic [STAGES-1:0][TW-1:0]          tnew_q, tnew_d;
  logic [CW-1:0]                      busy_q, busy_d;

  logic [NSRC-1:0][STAGES-1:0] match;
  logic                        found;
  logic [SW-1:0]               sel;
  logic [TW-1:0]               sel_tnew;

  // Zero URAs on either side never match, so duplicated lanes collapse into one hit.
  always_comb begin
    match = '0;
    for (int k = 0; k < NSRC; k++) begin
      for (int i = 0; i < STAGES; i++) begin
        for (int j = 0; j < NDEST; j++) begin
          if (vld_q[i] && (src_ura[k*URA_W +: URA_W] != '0) &&
              (ura_q[i][j*URA_W +: URA_W] == src_ura[k*URA_W +: URA_W]))
            match[k][i] = 1'b1;
        end
      end
    end
  end

  // Scan oldest to youngest so the youngest match overrides any older one.
  always_comb begin
    stall     = 1'b0;
    fwd_hit   = '0;
    fwd_stage = '0;
    found     = 1'b0;
    sel       = '0;
    sel_tnew  = '0;
    for (int k = 0; k < NSRC; k++) begin
      found    = 1'b0;
      sel      = '0;
      sel_tnew = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
        if (match[k][i]) begin
          found    = 1'b1;
          sel      = SW'(i);
          sel_tnew = tnew_q[i];
        end
      end
      if (found && (sel_tnew > src_tuse[k*TW +: TW]))
        stall = 1'b1;
      if (found && (sel_tnew == '0)) begin
        fwd_hit[k]             = 1'b1;
        fwd_stage[k*SW +: SW]  = sel;
      end
    end
  end

  always_comb begin
    vld_d  = vld_q;
    ura_d  = ura_q;
    tnew_d = tnew_q;
    if (flush) begin
      vld_d  = '0;
      ura_d  = '0;
      tnew_d = '0;
    end else if (advance) begin
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i]  = vld_q[i-1];
        ura_d[i]  = ura_q[i-1];
        tnew_d[i] = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - TW'(1);
      end
      if (issue_valid && !stall) begin
        vld_d[0]  = 1'b1;
        ura_d[0]  = issue_ura;
        tnew_d[0] = issue_tnew;
      end else begin
        vld_d[0]  = 1'b0;
        ura_d[0]  = '0;
        tnew_d[0] = '0;
      end
    end
    busy_d = '0;
    for (int i = 0; i < STAGES; i++)
      busy_d = busy_d + CW'(vld_d[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      ura_q  <= '0;
      tnew_q <= '0;
      busy_q <= '0;
    end else begin
      vld_q  <= vld_d;
      ura_q  <= ura_d;
      tnew_q <= tnew_d;
      busy_q <= busy_d;
    end
  end

  assign busy_count = busy_q;

endmodule

// File: tb/tb_ura_scoreboard.sv
// Directed bench for ura_scoreboard: hand-computed stall/forward/occupancy expectations per scenario.
module tb_ura_scoreboard;
  logic        clk;
  logic        reset_n;
  logic        issue_valid;
  logic [20:0] issue_ura;
  logic [1:0]  issue_tnew;
  logic        advance;
  logic        flush;
  logic [13:0] src_ura;
  logic [3:0]  src_tuse;
  logic        stall;
  logic [1:0]  fwd_hit;
  logic [3:0]  fwd_stage;
  logic [1:0]  busy_count;

  int checks = 0;
  int failures = 0;

  ura_scoreboard dut (
    .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid), .issue_ura(issue_ura),
    .issue_tnew(issue_tnew), .advance(advance), .flush(flush), .src_ura(src_ura),
    .src_tuse(src_tuse), .stall(stall), .fwd_hit(fwd_hit), .fwd_stage(fwd_stage),
    .busy_count(busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_ura = '0; issue_tnew = '0;
    advance = 1'b1; flush = 1'b0; src_ura = '0; src_tuse = '0;
  endtask

  task automatic clear();
    idle_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    src_ura = {7'd3, 7'd5};
    #2;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", stall); end
    checks++; if (fwd_hit !== 2'b00) begin failures++; $display("FAIL reset_fwd_hit got=%0h exp=0", fwd_hit); end
    checks++; if (fwd_stage !== 4'h0) begin failures++; $display("FAIL reset_fwd_stage got=%0h exp=0", fwd_stage); end
    checks++; if (busy_count !== 2'd0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", busy_count); end
    @(negedge clk);
    reset_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_load_use();
    clear();
    issue_valid = 1'b1; issue_ura = {14'd0, 7'd5}; issue_tnew = 2'd2;
    step();
    issue_valid = 1'b0; src_ura = {7'd0, 7'd5}; src_tuse = 4'd0;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall_c1 got=%0h exp=1", stall); end
    checks++; if (busy_count !== 2'd1) begin failures++; $display("FAIL lu_busy_c1 got=%0d exp=1", busy_count); end
    step();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall_c2 got=%0h exp=1", stall); end
    checks++; if (busy_count !== 2'd1) begin failures++; $display("FAIL lu_busy_c2 got=%0d exp=1", busy_count); end
    step();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_stall_c3 got=%0h exp=0", stall); end
    checks++; if (fwd_hit !== 2'b01) begin failures++; $display("FAIL lu_fwd_hit got=%0h exp=1", fwd_hit); end
    checks++; if (fwd_stage !== 4'b0010) begin failures++; $display("FAIL lu_fwd_stage got=%0h exp=2", fwd_stage); end
    checks++; if (busy_count !== 2'd1) begin failures++; $display("FAIL lu_busy_c3 got=%0d exp=1", busy_count); end
    step();
    checks++; if (busy_count !== 2'd0) begin failures++; $display("FAIL lu_busy_retired got=%0d exp=0", busy_count); end
    checks++; if (fwd_hit !== 2'b00) begin failures++; $display("FAIL lu_fwd_after_retire got=%0h exp=0", fwd_hit); end
  endtask

  task automatic test_youngest();
    clear();
    issue_valid = 1'b1; issue_ura = {14'd0, 7'd8}; issue_tnew = 2'd0;
    step();
    issue_tnew = 2'd1;
    step();
    issue_valid = 1'b0; advance = 1'b0;
    src_ura = {7'd0, 7'd8}; src_tuse = 4'd0;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL yw_stall_tuse0 got=%0h exp=1", stall); end
    checks++; if (fwd_hit !== 2'b00) begin failures++; $display("FAIL yw_fwd_tuse0 got=%0h exp=0", fwd_hit); end
    src_tuse = 4'd1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL yw_stall_tuse1 got=%0h exp=0", stall); end
    checks++; if (fwd_hit !== 2'b00) begin failures++; $display("FAIL yw_fwd_tuse1 got=%0h exp=0", fwd_hit); end
    checks++; if (fwd_stage !== 4'h0) begin failures++; $display("FAIL yw_fwd_stage got=%0h exp=0", fwd_stage); end
  endtask

  task automatic test_multilane();
    clear();
    issue_valid = 1'b1; issue_ura = {7'd0, 7'h41, 7'h40}; issue_tnew = 2'd0;
    step();
    issue_valid = 1'b0; advance = 1'b0;
    src_ura = {7'h41, 7'h00}; src_tuse = 4'd0;
    #1;
    checks++; if (fwd_hit !== 2'b10) begin failures++; $display("FAIL ml_fwd_hit got=%0h exp=2", fwd_hit); end
    checks++; if (fwd_stage !== 4'h0) begin failures++; $display("FAIL ml_fwd_stage got=%0h exp=0", fwd_stage); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ml_stall got=%0h exp=0", stall); end
    src_ura = {7'h41, 7'h40};
    #1;
    checks++; if (fwd_hit !== 2'b11) begin failures++; $display("FAIL ml_fwd_both got=%0h exp=3", fwd_hit); end
    src_ura = {7'h42, 7'h00};
    #1;
    checks++; if (fwd_hit !== 2'b00) begin failures++; $display("FAIL ml_no_match got=%0h exp=0", fwd_hit); end
  endtask

  task automatic test_freeze_flush();
    clear();
    issue_valid = 1'b1; issue_tnew = 2'd3;
    issue_ura = {14'd0, 7'd10}; step();
    issue_ura = {14'd0, 7'd11}; step();
    issue_ura = {14'd0, 7'd12}; step();
    issue_valid = 1'b0; advance = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (busy_count !== 2'd3) begin failures++; $display("FAIL ff_busy_frozen c=%0d got=%0d exp=3", c, busy_count); end
    end
    src_ura = {7'd0, 7'd10}; src_tuse = 4'd0;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL ff_tnew1_tuse0 got=%0h exp=1", stall); end
    src_tuse = 4'd1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ff_tnew1_tuse1 got=%0h exp=0", stall); end
    src_ura = {7'd0, 7'd11};
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL ff_tnew2_tuse1 got=%0h exp=1", stall); end
    flush = 1'b1; advance = 1'b1; issue_valid = 1'b1; issue_ura = {14'd0, 7'd13};
    step();
    flush = 1'b0; issue_valid = 1'b0;
    #1;
    checks++; if (busy_count !== 2'd0) begin failures++; $display("FAIL ff_flush_busy got=%0d exp=0", busy_count); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ff_flush_stall got=%0h exp=0", stall); end
  endtask

  task automatic test_stall_blocks_issue();
    clear();
    issue_valid = 1'b1; issue_ura = {14'd0, 7'd40}; issue_tnew = 2'd3;
    src_ura = {7'd0, 7'd40}; src_tuse = 4'd0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sb_self_match got=%0h exp=0", stall); end
    step();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sb_stall_after got=%0h exp=1", stall); end
    issue_ura = {14'd0, 7'd41};
    step();
    checks++; if (busy_count !== 2'd1) begin failures++; $display("FAIL sb_bubble_busy got=%0d exp=1", busy_count); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sb_stall_slot1 got=%0h exp=1", stall); end
    issue_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    clear();
    issue_valid = 1'b1; issue_tnew = 2'd3;
    issue_ura = {14'd0, 7'd20}; step();
    issue_ura = {14'd0, 7'd21}; step();
    issue_valid = 1'b0; advance = 1'b0;
    src_ura = {7'd0, 7'd21}; src_tuse = 4'd0;
    #1;
    checks++; if (busy_count !== 2'd2) begin failures++; $display("FAIL ar_busy_before got=%0d exp=2", busy_count); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL ar_stall_before got=%0h exp=1", stall); end
    reset_n = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ar_stall_async got=%0h exp=0", stall); end
    checks++; if (busy_count !== 2'd0) begin failures++; $display("FAIL ar_busy_async got=%0d exp=0", busy_count); end
    @(negedge clk);
    reset_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_retire();
    clear();
    issue_valid = 1'b1; issue_ura = {7'd30, 7'd30, 7'd30}; issue_tnew = 2'd1;
    step();
    issue_valid = 1'b0;
    checks++; if (busy_count !== 2'd1) begin failures++; $display("FAIL rt_busy0 got=%0d exp=1", busy_count); end
    step();
    checks++; if (busy_count !== 2'd1) begin failures++; $display("FAIL rt_busy1 got=%0d exp=1", busy_count); end
    step();
    checks++; if (busy_count !== 2'd1) begin failures++; $display("FAIL rt_busy2 got=%0d exp=1", busy_count); end
    src_ura = {7'd0, 7'd30}; src_tuse = 4'd0;
    #1;
    checks++; if (fwd_hit !== 2'b01) begin failures++; $display("FAIL rt_sat_fwd got=%0h exp=1", fwd_hit); end
    checks++; if (fwd_stage !== 4'b0010) begin failures++; $display("FAIL rt_sat_stage got=%0h exp=2", fwd_stage); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rt_sat_stall got=%0h exp=0", stall); end
    step();
    checks++; if (busy_count !== 2'd0) begin failures++; $display("FAIL rt_busy3 got=%0d exp=0", busy_count); end
    issue_valid = 1'b1; issue_ura = '0; issue_tnew = 2'd3; src_ura = {7'd0, 7'd0};
    step();
    issue_valid = 1'b0;
    checks++; if (busy_count !== 2'd1) begin failures++; $display("FAIL rt_zero_lane_busy got=%0d exp=1", busy_count); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rt_zero_lane_stall got=%0h exp=0", stall); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_youngest();
    test_multilane();
    test_freeze_flush();
    test_stall_blocks_issue();
    test_async_reset();
    test_retire();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
